// File: rtl/uart_periph.sv
// uart_periph: memory-mapped 8N1 UART with a single-frame transmitter and a
// receiver feeding a small circular FIFO that the core pops with word loads.
module uart_periph #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned RX_DEPTH     = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        uart_start,
  input  logic [7:0]                  tx_data,
  input  logic                        uart_read_en,
  output logic [31:0]                 rx_rdata,
  output logic                        tx,
  input  logic                        rx,
  output logic                        tx_busy,
  output logic [$clog2(RX_DEPTH):0]   rx_count,
  output logic                        rx_overflow,
  output logic                        rx_frame_err
);

  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam int unsigned AW = $clog2(RX_DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [BW-1:0] BIT_END  = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] HALF_END = BW'((CLKS_PER_BIT / 2) - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(RX_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  // ---------------------------------------------------------------- transmit
  uart_state_t    tx_state;
  logic [BW-1:0]  tx_baud;
  logic [2:0]     tx_bit;
  logic [7:0]     tx_shift;

  // Transmit FSM: start bit, eight data bits LSB first, stop bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= ST_IDLE;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      tx_baud  <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      case (tx_state)
        ST_IDLE: begin
          if (uart_start) begin
            tx_shift <= tx_data;
            tx_bit   <= '0;
            tx_baud  <= '0;
            tx       <= 1'b0;
            tx_busy  <= 1'b1;
            tx_state <= ST_START;
          end
        end
        ST_START: begin
          if (tx_baud == BIT_END) begin
            tx_baud  <= '0;
            tx       <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
            tx_state <= ST_DATA;
          end else begin
            tx_baud <= tx_baud + 1'b1;
          end
        end
        ST_DATA: begin
          if (tx_baud == BIT_END) begin
            tx_baud <= '0;
            if (tx_bit == 3'd7) begin
              tx       <= 1'b1;
              tx_state <= ST_STOP;
            end else begin
              tx_bit   <= tx_bit + 1'b1;
              tx       <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
            end
          end else begin
            tx_baud <= tx_baud + 1'b1;
          end
        end
        ST_STOP: begin
          if (tx_baud == BIT_END) begin
            tx_baud  <= '0;
            tx_busy  <= 1'b0;
            tx_state <= ST_IDLE;
          end else begin
            tx_baud <= tx_baud + 1'b1;
          end
        end
        default: tx_state <= ST_IDLE;
      endcase
    end
  end

  // ----------------------------------------------------------------- receive
  logic [1:0]     rx_sync;
  logic           rx_s;
  uart_state_t    rx_state;
  logic [BW-1:0]  rx_baud;
  logic [2:0]     rx_bit;
  logic [7:0]     rx_shift;

  // Two-flop synchronizer for the asynchronous serial input, idles high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_sync <= 2'b11;
    end else begin
      rx_sync <= {rx_sync[0], rx};
    end
  end

  assign rx_s = rx_sync[1];

  // Receive FSM: mid-bit start check, eight data samples, one stop sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state <= ST_IDLE;
      rx_baud  <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      case (rx_state)
        ST_IDLE: begin
          if (!rx_s) begin
            rx_baud  <= '0;
            rx_state <= ST_START;
          end
        end
        ST_START: begin
          if (rx_baud == HALF_END) begin
            rx_baud <= '0;
            rx_bit  <= '0;
            // A line that is high again at mid-start was only a glitch
            rx_state <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            rx_baud <= rx_baud + 1'b1;
          end
        end
        ST_DATA: begin
          if (rx_baud == BIT_END) begin
            rx_baud  <= '0;
            rx_shift <= {rx_s, rx_shift[7:1]};
            if (rx_bit == 3'd7) begin
              rx_state <= ST_STOP;
            end else begin
              rx_bit <= rx_bit + 1'b1;
            end
          end else begin
            rx_baud <= rx_baud + 1'b1;
          end
        end
        ST_STOP: begin
          if (rx_baud == BIT_END) begin
            rx_baud  <= '0;
            rx_state <= ST_IDLE;
          end else begin
            rx_baud <= rx_baud + 1'b1;
          end
        end
        default: rx_state <= ST_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------- fifo
  logic [7:0]     fifo_mem [RX_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           stop_smp;
  logic           fifo_full;
  logic           fifo_empty;
  logic           push;
  logic           pop;

  assign stop_smp   = (rx_state == ST_STOP) && (rx_baud == BIT_END);
  assign fifo_full  = (rx_count == FULL_CNT);
  assign fifo_empty = (rx_count == '0);
  assign pop        = uart_read_en && !fifo_empty;
  // A pop on the same edge frees the slot, so a full FIFO still accepts
  assign push       = stop_smp && rx_s && (!fifo_full || pop);

  // Sticky receive error flags, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_overflow  <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      if (stop_smp && rx_s && !push) begin
        rx_overflow <= 1'b1;
      end
      if (stop_smp && !rx_s) begin
        rx_frame_err <= 1'b1;
      end
    end
  end

  // Wrapping pointers and occupancy count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rx_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: rx_count <= rx_count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= rx_shift;
    end
  end

  // Single-cycle load data: head byte, or all ones when empty
  assign rx_rdata = fifo_empty ? 32'hFFFF_FFFF : {24'h0, fifo_mem[rd_ptr]};

endmodule
